// File: rtl/decompressor_stream_parser_if.sv
// Byte-stream input, item output and status lines of the LZRW1 stream parser.
interface decompressor_stream_parser_if;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_control;
  logic        out_valid;
  logic        out_stall;
  logic        stream_done;
  logic        error;

  // Stream source and item sink side (drives bytes, drives the downstream hold)
  modport master (
    output in_byte, in_valid, in_last, out_stall,
    input  in_ready, out_data, out_control, out_valid, stream_done, error
  );

  // Parser side
  modport slave (
    input  in_byte, in_valid, in_last, out_stall,
    output in_ready, out_data, out_control, out_valid, stream_done, error
  );
endinterface

// File: rtl/decompressor_stream_parser.sv
// LZRW1 stream parser: splits the compressed byte stream into control words
// and items, and presents each item as {16-bit data, copy flag} to the
// decompressor through a single-entry output register.
//
// state   | meaning
// --------+-----------------------------------------------
// CTRL_LO | waiting for control word low byte
// CTRL_HI | waiting for control word high byte
// ITEM    | waiting for a literal byte or copy byte0
// COPY2   | waiting for copy byte1 (byte0 held in r_byte0)
module decompressor_stream_parser (
  input logic                         clock,
  input logic                         reset,
  decompressor_stream_parser_if.slave bus
);

  typedef enum logic [1:0] {
    S_CTRL_LO = 2'd0,
    S_CTRL_HI = 2'd1,
    S_ITEM    = 2'd2,
    S_COPY2   = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_cw;
  logic [3:0]  r_idx;
  logic [7:0]  r_byte0;
  logic [15:0] r_out_data;
  logic        r_out_control;
  logic        r_out_valid;
  logic        r_done;
  logic        r_error;

  logic        w_flag;
  logic        w_out_free;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_consume;
  logic        w_last_group_item;
  logic [11:0] w_copy_offset;

  assign w_flag            = r_cw[r_idx];
  assign w_out_free        = !r_out_valid || !bus.out_stall;
  assign w_accept          = bus.in_valid && w_in_ready;
  assign w_consume         = r_out_valid && !bus.out_stall;
  assign w_last_group_item = (r_idx == 4'd15);
  assign w_copy_offset     = {r_byte0[7:4], bus.in_byte};

  // Ready: control bytes and copy byte0 never load the output register, so
  // only item-completing bytes wait for the output slot to free up.
  always_comb begin
    w_in_ready = 1'b1;
    case (r_state)
      S_CTRL_LO: w_in_ready = 1'b1;
      S_CTRL_HI: w_in_ready = 1'b1;
      S_ITEM:    w_in_ready = w_flag ? 1'b1 : w_out_free;
      S_COPY2:   w_in_ready = w_out_free;
      default:   w_in_ready = 1'b1;
    endcase
  end

  // Parser FSM, output register and status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_CTRL_LO;
      r_cw          <= 16'h0000;
      r_idx         <= 4'd0;
      r_byte0       <= 8'h00;
      r_out_data    <= 16'h0000;
      r_out_control <= 1'b0;
      r_out_valid   <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // A load below overrides this clear, giving back-to-back items.
      if (w_consume) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        case (r_state)
          S_CTRL_LO: begin
            if (bus.in_last) begin
              r_error <= 1'b1;
              r_state <= S_CTRL_LO;
            end else begin
              r_cw[7:0] <= bus.in_byte;
              r_state   <= S_CTRL_HI;
            end
          end
          S_CTRL_HI: begin
            if (bus.in_last) begin
              r_error <= 1'b1;
              r_state <= S_CTRL_LO;
            end else begin
              r_cw[15:8] <= bus.in_byte;
              r_idx      <= 4'd0;
              r_state    <= S_ITEM;
            end
          end
          S_ITEM: begin
            if (w_flag) begin
              if (bus.in_last) begin
                r_error <= 1'b1;
                r_state <= S_CTRL_LO;
              end else begin
                r_byte0 <= bus.in_byte;
                r_state <= S_COPY2;
              end
            end else begin
              r_out_data    <= {8'h00, bus.in_byte};
              r_out_control <= 1'b0;
              r_out_valid   <= 1'b1;
              if (bus.in_last) begin
                r_done  <= 1'b1;
                r_state <= S_CTRL_LO;
              end else if (w_last_group_item) begin
                r_state <= S_CTRL_LO;
              end else begin
                r_idx   <= r_idx + 4'd1;
                r_state <= S_ITEM;
              end
            end
          end
          S_COPY2: begin
            r_out_data    <= {r_byte0, bus.in_byte};
            r_out_control <= 1'b1;
            r_out_valid   <= 1'b1;
            // A zero offset would reference nothing; flag it but still pass it on.
            if (w_copy_offset == 12'd0) begin
              r_error <= 1'b1;
            end
            if (bus.in_last) begin
              r_done  <= 1'b1;
              r_state <= S_CTRL_LO;
            end else if (w_last_group_item) begin
              r_state <= S_CTRL_LO;
            end else begin
              r_idx   <= r_idx + 4'd1;
              r_state <= S_ITEM;
            end
          end
          default: r_state <= S_CTRL_LO;
        endcase
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_data    = r_out_data;
  assign bus.out_control = r_out_control;
  assign bus.out_valid   = r_out_valid;
  assign bus.stream_done = r_done;
  assign bus.error       = r_error;

endmodule

// File: tb/tb_decompressor_stream_parser.sv
// Self-checking bench for decompressor_stream_parser: expected items are
// queued as completing bytes are driven and compared as the DUT emits them.
module tb_decompressor_stream_parser;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  decompressor_stream_parser_if bus();

  decompressor_stream_parser dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int          tests_run = 0;
  int          fails     = 0;
  int          cyc       = 0;
  int          done_count = 0;
  logic [16:0] exp_q[$];
  int          pop_cyc[$];

  always @(posedge clock) cyc <= cyc + 1;

  // Output monitor: sample well after the falling edge, pop and compare on consume.
  always begin
    logic [16:0] exp;
    @(negedge clock);
    #2;
    if (!reset && bus.stream_done) done_count++;
    if (!reset && bus.out_valid && !bus.out_stall) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_item got %h/%b required none", bus.out_data, bus.out_control);
      end else begin
        exp = exp_q.pop_front();
        pop_cyc.push_back(cyc);
        if ({bus.out_control, bus.out_data} !== exp) begin
          fails++;
          $display("FAIL item got %h/%b required %h/%b", bus.out_data, bus.out_control,
                   exp[15:0], exp[16]);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic last);
    int n = 0;
    @(negedge clock);
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    #1;
    while (!bus.in_ready && n < 200) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (n >= 200) begin
      fails++;
      $display("FAIL send_timeout byte %h never accepted", b);
    end
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    repeat (4) @(negedge clock);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d items outstanding required 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.out_stall = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string name);
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000 || bus.out_control !== 1'b0 ||
        bus.stream_done !== 1'b0 || bus.error !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s got v=%b d=%h c=%b done=%b err=%b rdy=%b required 0/0000/0/0/0/1", name,
               bus.out_valid, bus.out_data, bus.out_control, bus.stream_done, bus.error,
               bus.in_ready);
    end
  endtask

  task automatic check_status(input string name, input int done_before, input int done_delta,
                              input logic err);
    tests_run++;
    if (done_count - done_before !== done_delta) begin
      fails++;
      $display("FAIL %s_done got %0d pulses required %0d", name, done_count - done_before, done_delta);
    end
    tests_run++;
    if (bus.error !== err) begin
      fails++;
      $display("FAIL %s_error got %b required %b", name, bus.error, err);
    end
  endtask

  task automatic test_reset();
    bus.in_byte = 8'h00; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_stall = 1'b0;
    do_reset();
    check_reset_values("reset");
  endtask

  task automatic test_literals();
    int d0 = done_count;
    pop_cyc.delete();
    send(8'h00, 0); send(8'h00, 0);
    exp_q.push_back({1'b0, 16'h0041}); send(8'h41, 0);
    exp_q.push_back({1'b0, 16'h0042}); send(8'h42, 0);
    exp_q.push_back({1'b0, 16'h0043}); send(8'h43, 1);
    drain();
    check_status("literals", d0, 1, 1'b0);
    tests_run++;
    if (pop_cyc.size() != 3 || pop_cyc[2] - pop_cyc[0] != 2) begin
      fails++;
      $display("FAIL literals_back_to_back got %0d items over span %0d required 3 over 2",
               pop_cyc.size(), (pop_cyc.size() == 3) ? pop_cyc[2] - pop_cyc[0] : -1);
    end
  endtask

  task automatic test_mixed();
    int d0 = done_count;
    send(8'h01, 0); send(8'h00, 0);
    send(8'h12, 0);
    exp_q.push_back({1'b1, 16'h1234}); send(8'h34, 0);
    exp_q.push_back({1'b0, 16'h0055}); send(8'h55, 1);
    drain();
    check_status("mixed", d0, 1, 1'b0);
  endtask

  task automatic test_group_wrap();
    int d0 = done_count;
    logic [7:0] b0, b1;
    send(8'hFF, 0); send(8'hFF, 0);
    for (int k = 0; k < 16; k++) begin
      b0 = 8'h10 + 8'(k);
      b1 = 8'(k * 3 + 1);
      send(b0, 0);
      exp_q.push_back({1'b1, b0, b1});
      send(b1, 0);
    end
    send(8'h00, 0); send(8'h00, 0);
    exp_q.push_back({1'b0, 16'h0077}); send(8'h77, 1);
    drain();
    check_status("group_wrap", d0, 1, 1'b0);
  endtask

  task automatic test_stall();
    int d0 = done_count;
    pop_cyc.delete();
    @(negedge clock);
    bus.out_stall = 1'b1;
    send(8'h00, 0); send(8'h00, 0);
    exp_q.push_back({1'b0, 16'h0041}); send(8'h41, 0);
    @(negedge clock);
    bus.in_byte = 8'h42; bus.in_valid = 1'b1; bus.in_last = 1'b1;
    exp_q.push_back({1'b0, 16'h0042});
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clock);
      #1;
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0041 || bus.in_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold cycle %0d got v=%b d=%h rdy=%b required 1/0041/0", i,
                 bus.out_valid, bus.out_data, bus.in_ready);
      end
    end
    @(negedge clock);
    bus.out_stall = 1'b0;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL stall_release_ready got %b required 1", bus.in_ready);
    end
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    drain();
    check_status("stall", d0, 1, 1'b0);
    tests_run++;
    if (pop_cyc.size() != 2 || pop_cyc[1] - pop_cyc[0] != 1) begin
      fails++;
      $display("FAIL stall_followup got %0d items required 2 on consecutive cycles", pop_cyc.size());
    end
  endtask

  task automatic test_offset_zero();
    int d0 = done_count;
    send(8'h01, 0); send(8'h00, 0);
    send(8'h05, 0);
    exp_q.push_back({1'b1, 16'h0500}); send(8'h00, 1);
    drain();
    check_status("offset_zero", d0, 1, 1'b1);
  endtask

  task automatic test_truncation();
    int d0;
    do_reset();
    d0 = done_count;
    send(8'h01, 0); send(8'h00, 0); send(8'h12, 1);
    drain();
    check_status("truncation", d0, 0, 1'b1);
    d0 = done_count;
    send(8'h00, 0); send(8'h00, 0);
    exp_q.push_back({1'b0, 16'h0041}); send(8'h41, 1);
    drain();
    check_status("after_truncation", d0, 1, 1'b1);
  endtask

  task automatic test_reset_mid_copy();
    int d0;
    send(8'h01, 0); send(8'h00, 0); send(8'h12, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check_reset_values("reset_mid_copy");
    d0 = done_count;
    send(8'h00, 0); send(8'h00, 0);
    exp_q.push_back({1'b0, 16'h0055}); send(8'h55, 1);
    drain();
    check_status("reset_mid_copy", d0, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_literals();
    test_mixed();
    test_group_wrap();
    test_stall();
    test_offset_zero();
    test_truncation();
    test_reset_mid_copy();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached");
    $fatal(1);
  end

endmodule
